riscv_mem_responder: RTL and testbench
======================================

# riscv_mem_responder

Memory-side responder for `riscvPipeline`: serves the core's instruction-fetch port and data port from on-chip RAM, and hosts the boot loader that fills that RAM from a byte stream while the core is held in reset. It also decodes a single "tohost" MMIO word that the program writes to report completion. It sits between the core and the board-level loader (UART/JTAG byte source) and replaces the behavioural memories used in simulation.

## Interface
- `ADDR_WIDTH`, 10, word-address width of each RAM (depth = 2^ADDR_WIDTH words).
- `TOHOST_ADDR`, 32'hFFFF_FFF0, byte address of the completion register.
- `clk` in 1, single clock; all logic on rising edge.
- `reset_n` in 1, reset is asynchronous and active-low.
- `load_valid` in 1, `load_byte` in 8, `load_last` in 1, boot byte stream; `load_last` marks the final byte.
- `load_ready` out 1, loader accepts a byte on `load_valid && load_ready`.
- `load_overflow` out 1, sticky: bytes arrived beyond RAM capacity.
- `core_reset_n` out 1, drives the core's `reset_n`.
- `instructionAddress` in 30, word address of fetch.
- `instruction` out 32, fetched word.
- `instructionStall` out 1, fetch not valid this cycle.
- `readAddress` in 32, `writeAddress` in 32, byte addresses.
- `writeData` in 32, `writeStrobe` in 4, store data and byte enables (bit i → bits 8i+7:8i).
- `memoryData` out 32, load data.
- `done` out 1, `result` out 32, program completion flag and value.

## Operation
- States: LOAD, RUN, HALT. Reset → LOAD.
- LOAD: `load_ready`=1, `core_reset_n`=0, `instructionStall`=1; core writes ignored. Bytes assembled little-endian (first byte → bits 7:0). On 4th byte, or on `load_last`, word written to both instruction RAM and data RAM at word counter, counter +1, byte counter cleared; missing upper bytes of a partial final word are 0.
- `load_last` accepted → RUN. Word counter reaching 2^ADDR_WIDTH does not wrap: further bytes accepted and dropped, `load_overflow` set (cleared only by reset).
- RUN: `core_reset_n`=1, `instructionStall`=0, `load_ready`=0. Fetch reads instruction RAM[`instructionAddress[ADDR_WIDTH-1:0]`]; upper bits ignored.
- Data read: word index `readAddress[ADDR_WIDTH+1:2]`; addresses ≥ 4·2^ADDR_WIDTH return 0.
- Data write when `writeStrobe`≠0: `writeAddress`==`TOHOST_ADDR` → `result`←`writeData`, `done`←1, state → HALT, RAM untouched. Other in-range addresses: byte-enabled write to data RAM only. Out-of-range: ignored.
- Read and write to the same word in one cycle: `memoryData` returns the old word.
- HALT: `instructionStall`=1, `core_reset_n` stays 1, data port still serviced, `done`/`result` held until reset.
- Reset values: `instruction`=0, `memoryData`=0, `instructionStall`=1, `core_reset_n`=0, `load_ready`=1 (LOAD), `load_overflow`=0, `done`=0, `result`=0.
- Reset mid-load: counters cleared, loading restarts at word 0; RAM contents not cleared.

## Timing
- Fetch and data-read latency 1 cycle: address at edge N → data valid after edge N+1, registered.
- Loader: one byte per cycle max; completed word written at the edge that accepts its 4th/last byte.
- `load_last` accepted at edge N → state RUN and `core_reset_n`=1, `instructionStall`=0, `load_ready`=0 after edge N.
- Tohost write at edge N → `done`=1, `result` valid, `instructionStall`=1 after edge N.
- `core_reset_n` driven from a flop, glitch-free.

## Structure
- Package `riscv_mem_pkg`: state enum (LOAD/RUN/HALT), word width 32, strobe width 4, default `TOHOST_ADDR`.
- Sub-module `riscv_bram_be`: 1 write port with byte enables + 1 registered read port, read-before-write; instantiated twice (instruction, data). Instruction instance uses full-word strobe from loader only.
- Top holds FSM, byte assembler, word counter, address decode, tohost register.

## Test plan
- Stream 13 00 00 00 93 00 10 00 (`load_last` on final byte) → imem[0]=0x00000013, imem[1]=0x00100093; `core_reset_n` high one edge after last byte; fetch address 1 → `instruction`=0x00100093 next cycle.
- Stream 5 bytes ending AA with `load_last` → word 1 = 0x000000AA, state RUN.
- Data word 4 = 0x11223344; write addr 16, strobe 4'b0100, data 0xDEADBEEF → read addr 16 returns 0x11AD3344; same-cycle read of addr 16 returns 0x11223344.
- Write 42 to 0xFFFF_FFF0 → next cycle `done`=1, `result`=42, `instructionStall`=1; data RAM unchanged.
- ADDR_WIDTH=2, stream 20 bytes → first 16 stored, `load_overflow`=1; read addr 64 → 0.
- Assert `reset_n` low after 6 bytes, restart with 4 new bytes → word 0 holds new bytes, word 1 keeps old partial contents, outputs at reset values during reset.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the riscvPipeline memory responder.
// Covers the responder state, data word geometry and the default completion address.
package riscv_mem_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = 4;
    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        StLoad,
        StRun,
        StHalt
    } memState_e;

endpackage

// File: rtl/riscv_bram_be.sv
// Single-port-write / single-port-read block RAM with byte enables.
// The read port is registered, so a same-cycle read of the word being written returns the old word.
module riscv_bram_be
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [STRB_WIDTH-1:0] writeStrobe,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [WORD_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    output logic [WORD_WIDTH-1:0] readData
);

    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Array is deliberately not reset so that contents survive a reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (writeStrobe[i]) begin
                mem[writeAddr][8*i +: 8] <= writeData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readData <= '0;
        end else begin
            readData <= mem[readAddr];
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Instruction/data memory responder with a boot byte-stream loader and a tohost completion word.
// The core is held in reset while the loader fills both RAMs.
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_overflow,
    output logic                  core_reset_n,
    input  logic [29:0]           instructionAddress,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic                  instructionStall,
    input  logic [31:0]           readAddress,
    input  logic [31:0]           writeAddress,
    input  logic [WORD_WIDTH-1:0] writeData,
    input  logic [STRB_WIDTH-1:0] writeStrobe,
    output logic [WORD_WIDTH-1:0] memoryData,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] result
);

    memState_e stateQ, stateD;

    logic [1:0]            byteCntQ;
    logic [ADDR_WIDTH:0]   wordCntQ;
    logic [WORD_WIDTH-1:0] wordBufQ;
    logic                  overflowQ;
    logic                  coreResetNQ;
    logic                  doneQ;
    logic [WORD_WIDTH-1:0] resultQ;
    logic                  readInRangeQ;

    logic                  byteAccept, wordComplete, ramHasRoom, loadWrite;
    logic [WORD_WIDTH-1:0] assembled;
    logic                  coreWriteActive, tohostHit, writeInRange, coreWrite;

    logic [STRB_WIDTH-1:0] imemStrobe, dmemStrobe;
    logic [ADDR_WIDTH-1:0] dmemWriteAddr;
    logic [WORD_WIDTH-1:0] dmemWriteData, instrRead, dataRead;

    logic unusedAddrBits;
    assign unusedAddrBits = ^{instructionAddress[29:ADDR_WIDTH], readAddress[1:0]};

    always_comb begin
        byteAccept   = (stateQ == StLoad) && load_valid;
        assembled    = wordBufQ | ({24'b0, load_byte} << {byteCntQ, 3'b000});
        wordComplete = byteAccept && ((byteCntQ == 2'd3) || load_last);
        ramHasRoom   = !wordCntQ[ADDR_WIDTH];
        loadWrite    = wordComplete && ramHasRoom;

        coreWriteActive = (stateQ != StLoad) && (writeStrobe != '0);
        tohostHit       = coreWriteActive && (stateQ == StRun) && (writeAddress == TOHOST_ADDR);
        writeInRange    = (writeAddress[31:ADDR_WIDTH+2] == '0);
        coreWrite       = coreWriteActive && writeInRange && (writeAddress != TOHOST_ADDR);
    end

    // The loader owns the data RAM write port in LOAD; the core owns it afterwards.
    always_comb begin
        imemStrobe    = loadWrite ? '1 : '0;
        dmemStrobe    = '0;
        dmemWriteAddr = wordCntQ[ADDR_WIDTH-1:0];
        dmemWriteData = assembled;
        if (loadWrite) begin
            dmemStrobe = '1;
        end else if (coreWrite) begin
            dmemStrobe    = writeStrobe;
            dmemWriteAddr = writeAddress[ADDR_WIDTH+1:2];
            dmemWriteData = writeData;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= StLoad;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StLoad:  if (byteAccept && load_last) stateD = StRun;
            StRun:   if (tohostHit) stateD = StHalt;
            StHalt:  stateD = StHalt;
            default: stateD = StLoad;
        endcase
    end

    always_comb begin
        load_ready       = (stateQ == StLoad);
        instructionStall = (stateQ != StRun);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byteCntQ     <= '0;
            wordCntQ     <= '0;
            wordBufQ     <= '0;
            overflowQ    <= 1'b0;
            coreResetNQ  <= 1'b0;
            doneQ        <= 1'b0;
            resultQ      <= '0;
            readInRangeQ <= 1'b0;
        end else begin
            if (byteAccept) begin
                if (wordComplete) begin
                    byteCntQ <= '0;
                    wordBufQ <= '0;
                end else begin
                    byteCntQ <= byteCntQ + 2'd1;
                    wordBufQ <= assembled;
                end
                if (!ramHasRoom) overflowQ <= 1'b1;
            end
            if (loadWrite) wordCntQ <= wordCntQ + 1'b1;
            if (tohostHit) begin
                doneQ   <= 1'b1;
                resultQ <= writeData;
            end
            coreResetNQ  <= (stateD != StLoad);
            readInRangeQ <= (readAddress[31:ADDR_WIDTH+2] == '0);
        end
    end

    riscv_bram_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_imem (
        .clk        (clk),
        .reset_n    (reset_n),
        .writeStrobe(imemStrobe),
        .writeAddr  (wordCntQ[ADDR_WIDTH-1:0]),
        .writeData  (assembled),
        .readAddr   (instructionAddress[ADDR_WIDTH-1:0]),
        .readData   (instrRead)
    );

    riscv_bram_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_dmem (
        .clk        (clk),
        .reset_n    (reset_n),
        .writeStrobe(dmemStrobe),
        .writeAddr  (dmemWriteAddr),
        .writeData  (dmemWriteData),
        .readAddr   (readAddress[ADDR_WIDTH+1:2]),
        .readData   (dataRead)
    );

    assign instruction   = instrRead;
    assign memoryData    = readInRangeQ ? dataRead : '0;
    assign load_overflow = overflowQ;
    assign core_reset_n  = coreResetNQ;
    assign done          = doneQ;
    assign result        = resultQ;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Randomised self-checking bench for riscv_mem_responder against a word/byte-array model.
// A second small instance (ADDR_WIDTH=2) exercises loader overflow.
module tb_riscv_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN, loadValid, loadLast, loadReady, loadOverflow, coreResetN;
    logic [7:0]  loadByte;
    logic [29:0] instrAddr;
    logic [31:0] instr, readAddr, writeAddr, writeData, memData, result;
    logic [3:0]  writeStrobe;
    logic        instrStall, done;

    logic        resetNB, loadValidB, loadLastB, loadReadyB, loadOverflowB, coreResetNB;
    logic [7:0]  loadByteB;
    logic [29:0] instrAddrB;
    logic [31:0] instrB, readAddrB, writeAddrB, writeDataB, memDataB, resultB;
    logic [3:0]  writeStrobeB;
    logic        instrStallB, doneB;

    riscv_mem_responder #(.ADDR_WIDTH(10), .TOHOST_ADDR(32'hFFFF_FFF0)) dutA (
        .clk(clk), .reset_n(resetN), .load_valid(loadValid), .load_byte(loadByte),
        .load_last(loadLast), .load_ready(loadReady), .load_overflow(loadOverflow),
        .core_reset_n(coreResetN), .instructionAddress(instrAddr), .instruction(instr),
        .instructionStall(instrStall), .readAddress(readAddr), .writeAddress(writeAddr),
        .writeData(writeData), .writeStrobe(writeStrobe), .memoryData(memData),
        .done(done), .result(result)
    );

    riscv_mem_responder #(.ADDR_WIDTH(2), .TOHOST_ADDR(32'hFFFF_FFF0)) dutB (
        .clk(clk), .reset_n(resetNB), .load_valid(loadValidB), .load_byte(loadByteB),
        .load_last(loadLastB), .load_ready(loadReadyB), .load_overflow(loadOverflowB),
        .core_reset_n(coreResetNB), .instructionAddress(instrAddrB), .instruction(instrB),
        .instructionStall(instrStallB), .readAddress(readAddrB), .writeAddress(writeAddrB),
        .writeData(writeDataB), .writeStrobe(writeStrobeB), .memoryData(memDataB),
        .done(doneB), .result(resultB)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] mImem [1024];
    logic [31:0] mDmem [1024];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        loadValid = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
        loadValid = 1'b1;
        loadByte  = b;
        loadLast  = last;
        tick();
        loadValid = 1'b0;
        loadLast  = 1'b0;
        loadByte  = 8'($urandom);
    endtask

    task automatic send_byte_b(input logic [7:0] b, input logic last);
        loadValidB = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
        loadValidB = 1'b1;
        loadByteB  = b;
        loadLastB  = last;
        tick();
        loadValidB = 1'b0;
        loadLastB  = 1'b0;
    endtask

    // Little-endian packing; a trailing partial word is stored only when the stream was ended.
    task automatic model_load(input logic [7:0] bytes[$], input bit ended);
        int n;
        logic [31:0] w;
        n = bytes.size();
        for (int i = 0; i < n; i += 4) begin
            if (i + 4 <= n || ended) begin
                w = 32'h0;
                for (int k = 0; k < 4; k++) begin
                    if (i + k < n) w = w + (32'(bytes[i+k]) << (8 * k));
                end
                mImem[i/4] = w;
                mDmem[i/4] = w;
            end
        end
    endtask

    task automatic do_reset();
        resetN      = 1'b0;
        loadValid   = 1'b0;
        loadLast    = 1'b0;
        writeStrobe = 4'h0;
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #2;
        total++;
        if ({instr, memData, instrStall, coreResetN, loadReady, loadOverflow, done, result} !==
            {32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_values got instr=%h mem=%h stall=%b crst=%b rdy=%b ovf=%b done=%b res=%h",
                     instr, memData, instrStall, coreResetN, loadReady, loadOverflow, done, result);
        end
        tick();
        resetN = 1'b1;
        tick();
        total++;
        if ({loadReady, coreResetN, instrStall} !== 3'b101) begin
            bad++;
            $display("FAIL idle_load got rdy/crst/stall=%b exp=101", {loadReady, coreResetN, instrStall});
        end
    endtask

    task automatic test_boot_directed();
        logic [7:0] q[$];
        q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 7; i++) send_byte(q[i], 1'b0);
        total++;
        if (coreResetN !== 1'b0) begin
            bad++;
            $display("FAIL core_held got=%b exp=0", coreResetN);
        end
        send_byte(q[7], 1'b1);
        model_load(q, 1'b1);
        total++;
        if ({coreResetN, instrStall, loadReady} !== 3'b100) begin
            bad++;
            $display("FAIL enter_run got crst/stall/rdy=%b exp=100", {coreResetN, instrStall, loadReady});
        end
        instrAddr = 30'd1;
        tick();
        total++;
        if (instr !== 32'h0010_0093) begin
            bad++;
            $display("FAIL fetch_word1 got=%h exp=%h", instr, 32'h0010_0093);
        end
        instrAddr = 30'd0;
        readAddr  = 32'd4;
        tick();
        total++;
        if (instr !== 32'h0000_0013 || memData !== 32'h0010_0093) begin
            bad++;
            $display("FAIL boot_both_rams got instr=%h mem=%h exp 00000013 00100093", instr, memData);
        end
    endtask

    task automatic test_partial_word();
        logic [7:0] q[$];
        do_reset();
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        q.push_back(8'hAA);
        for (int i = 0; i < 5; i++) send_byte(q[i], i == 4);
        model_load(q, 1'b1);
        total++;
        if (instrStall !== 1'b0) begin
            bad++;
            $display("FAIL partial_run got stall=%b exp=0", instrStall);
        end
        instrAddr = 30'd1;
        tick();
        instrAddr = 30'd0;
        total++;
        if (instr !== 32'h0000_00AA) begin
            bad++;
            $display("FAIL partial_word got=%h exp=000000aa", instr);
        end
        tick();
        total++;
        if (instr !== mImem[0]) begin
            bad++;
            $display("FAIL partial_word0 got=%h exp=%h", instr, mImem[0]);
        end
    endtask

    task automatic test_random_load();
        logic [7:0] q[$];
        int n;
        do_reset();
        n = $urandom_range(9, 48);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        for (int i = 0; i < n; i++) send_byte(q[i], i == n - 1);
        model_load(q, 1'b1);
        for (int w = 0; w < (n + 3) / 4; w++) begin
            instrAddr = {20'($urandom), 10'(w)};
            readAddr  = 32'(w * 4 + $urandom_range(0, 3));
            tick();
            total++;
            if (instr !== mImem[w] || memData !== mDmem[w]) begin
                bad++;
                $display("FAIL rand_load w=%0d got instr=%h mem=%h exp %h %h",
                         w, instr, memData, mImem[w], mDmem[w]);
            end
        end
    endtask

    // Random reads/writes on words 0..15 plus out-of-range traffic; reads see the pre-write word.
    task automatic test_data_port();
        int rw, ww;
        bit rIn, wIn;
        logic [31:0] exp;
        for (int w = 0; w < 16; w++) begin
            writeAddr   = 32'(w * 4);
            writeData   = $urandom;
            writeStrobe = 4'hF;
            mDmem[w]    = writeData;
            tick();
        end
        for (int c = 0; c < 60; c++) begin
            rIn = ($urandom_range(0, 4) != 0);
            wIn = ($urandom_range(0, 4) != 0);
            rw  = $urandom_range(0, 15);
            ww  = $urandom_range(0, 15);
            readAddr    = rIn ? 32'(rw * 4 + $urandom_range(0, 3)) : 32'h1000 + $urandom_range(0, 65535);
            writeAddr   = wIn ? 32'(ww * 4 + $urandom_range(0, 3)) : 32'h1000 + $urandom_range(0, 65535);
            writeData   = $urandom;
            writeStrobe = 4'($urandom);
            exp = rIn ? mDmem[rw] : 32'h0;
            tick();
            total++;
            if (memData !== exp) begin
                bad++;
                $display("FAIL data_rand c=%0d addr=%h got=%h exp=%h", c, readAddr, memData, exp);
            end
            if (wIn) begin
                for (int k = 0; k < 4; k++) begin
                    if (writeStrobe[k]) mDmem[ww][8*k +: 8] = writeData[8*k +: 8];
                end
            end
        end
        writeStrobe = 4'h0;
        for (int w = 0; w < 4; w++) begin
            instrAddr = 30'(w);
            tick();
            total++;
            if (instr !== mImem[w]) begin
                bad++;
                $display("FAIL imem_untouched w=%0d got=%h exp=%h", w, instr, mImem[w]);
            end
        end
    endtask

    task automatic test_byte_enable();
        writeAddr   = 32'd16;
        writeData   = 32'h1122_3344;
        writeStrobe = 4'hF;
        tick();
        writeData   = 32'hDEAD_BEEF;
        writeStrobe = 4'b0100;
        readAddr    = 32'd16;
        tick();
        writeStrobe = 4'h0;
        total++;
        if (memData !== 32'h1122_3344) begin
            bad++;
            $display("FAIL read_before_write got=%h exp=11223344", memData);
        end
        tick();
        total++;
        if (memData !== 32'h11AD_3344) begin
            bad++;
            $display("FAIL byte_enable got=%h exp=11ad3344", memData);
        end
        mDmem[4] = 32'h11AD_3344;
    endtask

    task automatic test_tohost();
        writeAddr   = 32'hFFFF_FFF0;
        writeData   = 32'd42;
        writeStrobe = 4'hF;
        readAddr    = 32'd16;
        tick();
        writeStrobe = 4'h0;
        total++;
        if ({done, result, instrStall, coreResetN} !== {1'b1, 32'd42, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL tohost got done=%b res=%h stall=%b crst=%b exp 1 0000002a 1 1",
                     done, result, instrStall, coreResetN);
        end
        tick();
        total++;
        if (memData !== mDmem[4]) begin
            bad++;
            $display("FAIL tohost_no_ram got=%h exp=%h", memData, mDmem[4]);
        end
        writeAddr   = 32'hFFFF_FFF0;
        writeData   = 32'd99;
        writeStrobe = 4'hF;
        tick();
        writeAddr = 32'd20;
        writeData = 32'hCAFE_F00D;
        tick();
        writeStrobe = 4'h0;
        readAddr    = 32'd20;
        tick();
        total++;
        if (result !== 32'd42 || done !== 1'b1) begin
            bad++;
            $display("FAIL halt_hold got done=%b res=%h exp 1 0000002a", done, result);
        end
        total++;
        if (memData !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL halt_data got=%h exp=cafef00d", memData);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        logic [31:0] w;
        resetNB = 1'b0;
        tick();
        resetNB = 1'b1;
        tick();
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 16; i++) send_byte_b(q[i], 1'b0);
        total++;
        if (loadOverflowB !== 1'b0) begin
            bad++;
            $display("FAIL ovf_at_capacity got=%b exp=0", loadOverflowB);
        end
        for (int i = 16; i < 20; i++) send_byte_b(q[i], i == 19);
        total++;
        if ({loadOverflowB, instrStallB, loadReadyB, coreResetNB, doneB} !== 5'b10010) begin
            bad++;
            $display("FAIL ovf_state got ovf/stall/rdy/crst/done=%b exp=10010",
                     {loadOverflowB, instrStallB, loadReadyB, coreResetNB, doneB});
        end
        for (int a = 0; a < 5; a++) begin
            instrAddrB = 30'(a);
            tick();
            w = {q[(a%4)*4+3], q[(a%4)*4+2], q[(a%4)*4+1], q[(a%4)*4]};
            total++;
            if (instrB !== w) begin
                bad++;
                $display("FAIL ovf_word a=%0d got=%h exp=%h", a, instrB, w);
            end
        end
        readAddrB = 32'd64;
        tick();
        total++;
        if (memDataB !== 32'h0 || resultB !== 32'h0) begin
            bad++;
            $display("FAIL ovf_oob_read got=%h res=%h exp 0", memDataB, resultB);
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] q[$];
        logic [31:0] old1;
        do_reset();
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 8; i++) send_byte(q[i], i == 7);
        model_load(q, 1'b1);
        old1 = mImem[1];
        do_reset();
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) send_byte(q[i], 1'b0);
        model_load(q, 1'b0);
        resetN = 1'b0;
        #2;
        total++;
        if ({instr, memData, instrStall, coreResetN, loadReady, loadOverflow, done, result} !==
            {32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL midload_reset got instr=%h mem=%h stall=%b crst=%b rdy=%b done=%b",
                     instr, memData, instrStall, coreResetN, loadReady, done);
        end
        tick();
        resetN = 1'b1;
        tick();
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) send_byte(q[i], i == 3);
        model_load(q, 1'b1);
        for (int w = 0; w < 2; w++) begin
            instrAddr = 30'(w);
            readAddr  = 32'(w * 4);
            tick();
            total++;
            if (instr !== mImem[w] || memData !== mDmem[w]) begin
                bad++;
                $display("FAIL midload_word w=%0d got instr=%h mem=%h exp %h %h",
                         w, instr, memData, mImem[w], mDmem[w]);
            end
        end
        total++;
        if (mImem[1] !== old1 || instr !== old1) begin
            bad++;
            $display("FAIL midload_keep got=%h exp=%h", instr, old1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0; loadValid = 1'b0; loadLast = 1'b0; loadByte = 8'h0;
        instrAddr = '0; readAddr = '0; writeAddr = '0; writeData = '0; writeStrobe = '0;
        resetNB = 1'b0; loadValidB = 1'b0; loadLastB = 1'b0; loadByteB = 8'h0;
        instrAddrB = '0; readAddrB = '0; writeAddrB = '0; writeDataB = '0; writeStrobeB = '0;
        for (int i = 0; i < 1024; i++) begin
            mImem[i] = 32'h0;
            mDmem[i] = 32'h0;
        end
        #3;
        test_reset();
        test_boot_directed();
        test_partial_word();
        test_random_load();
        test_data_port();
        test_byte_enable();
        test_tohost();
        test_overflow();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
